// File: rtl/skew_mem.sv
// Double-banked DIM x DIM matrix buffer that streams a committed bank as a
// diagonally skewed wavefront, row-major or transposed, one lane per column.
module skew_mem #(
    parameter int BITS = 8,
    parameter int DIM  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS-1:0]     wr_data,
    input  logic                    wr_commit,
    input  logic                    start,
    input  logic                    transpose,
    output logic [DIM*BITS-1:0]     out_data,
    output logic [DIM-1:0]          out_valid,
    output logic                    busy,
    output logic                    bank_ready,
    output logic                    wr_full,
    output logic                    done
);
    localparam int RW = $clog2(DIM);
    localparam int TW = $clog2(2*DIM);
    localparam logic [TW-1:0] LAST = TW'(2*DIM-2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state, state_n;
    logic [TW-1:0] t, t_n;
    logic          mode, mode_n;
    logic          wb, wb_n, rb, rb_n;
    logic [1:0]    cnt, cnt_n;
    logic          do_write, do_commit, last_step;

    // Each bank row is stored packed exactly as it arrives on wr_data.
    logic [DIM*BITS-1:0] mem [2][DIM];

    // NOTE: the banks carry no reset; only the pointers and count decide what
    // is valid, so reset simply forgets whatever the banks still hold.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wb][wr_row] <= wr_data;
    end

    // NOTE: every comb output is defaulted up front so no path infers a latch.
    always_comb begin
        state_n   = state;
        t_n       = t;
        mode_n    = mode;
        wb_n      = wb;
        rb_n      = rb;
        do_write  = wr_en && (cnt != 2'd2);
        do_commit = wr_commit && (cnt != 2'd2);
        last_step = (state == STREAM) && (t == LAST);
        cnt_n     = cnt + 2'(do_commit) - 2'(last_step);
        if (do_commit)
            wb_n = ~wb;
        if (last_step)
            rb_n = ~rb;
        case (state)
            IDLE: begin
                if (start && cnt != 2'd0) begin
                    state_n = STREAM;
                    t_n     = '0;
                    mode_n  = transpose;
                end
            end
            STREAM: begin
                if (last_step) begin
                    // Another bank already counted after this edge: restart with no idle gap.
                    t_n = '0;
                    if (start && cnt_n != 2'd0)
                        mode_n = transpose;
                    else
                        state_n = IDLE;
                end else begin
                    t_n = t + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            mode       <= 1'b0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            cnt        <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bank_ready <= 1'b0;
            wr_full    <= 1'b0;
        end else begin
            state      <= state_n;
            t          <= t_n;
            mode       <= mode_n;
            wb         <= wb_n;
            rb         <= rb_n;
            cnt        <= cnt_n;
            busy       <= (state == STREAM);
            done       <= last_step;
            bank_ready <= (cnt_n != 2'd0);
            wr_full    <= (cnt_n == 2'd2);
        end
    end

    // Lane g shows element k = t - g of its row (or column when transposed).
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        logic [BITS-1:0] row_cols [DIM];
        logic [RW-1:0]   k;
        logic            in_range;
        logic [BITS-1:0] lane_val;
        logic [BITS-1:0] data_r;
        logic            valid_r;

        for (genvar h = 0; h < DIM; h++) begin : g_col
            assign row_cols[h] = mem[rb][g][h*BITS +: BITS];
        end

        assign in_range = (state == STREAM) && (int'(t) >= g) && (int'(t) < g + DIM);
        assign k        = RW'(int'(t) - g);
        assign lane_val = mode ? mem[rb][k][g*BITS +: BITS] : row_cols[k];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_r  <= '0;
                valid_r <= 1'b0;
            end else begin
                data_r  <= in_range ? lane_val : '0;
                valid_r <= in_range;
            end
        end

        assign out_data[g*BITS +: BITS] = data_r;
        assign out_valid[g]             = valid_r;
    end
endmodule

// File: tb/tb_skew_mem.sv
// Directed bench for skew_mem at DIM=4, BITS=8: streaming order, transpose,
// back-to-back banks, full-buffer rejection and asynchronous reset mid-stream.
module tb_skew_mem;
    localparam int BITS = 8;
    localparam int DIM  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_row = '0;
    logic [31:0] wr_data = '0;
    logic        wr_commit = 1'b0;
    logic        start = 1'b0;
    logic        transpose = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        busy, bank_ready, wr_full, done;

    int checks = 0;
    int errors = 0;

    skew_mem #(.BITS(BITS), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_commit(wr_commit), .start(start), .transpose(transpose),
        .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .bank_ready(bank_ready), .wr_full(wr_full), .done(done)
    );

    always #5 clk = ~clk;

    // Matrix packed with element (i,j) at bits [(i*4+j)*8 +: 8].
    function automatic logic [127:0] mk_mat(input int kind);
        logic [127:0] m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                case (kind)
                    0: m[(i*4+j)*8 +: 8] = 8'(10*i + j);
                    1: m[(i*4+j)*8 +: 8] = 8'(-(4*i + j + 1));
                    2: m[(i*4+j)*8 +: 8] = 8'(50 + 4*i + j);
                    default: m[(i*4+j)*8 +: 8] = 8'(90 + 2*i + 3*j);
                endcase
        return m;
    endfunction

    function automatic logic [3:0] exp_valid(input int t);
        logic [3:0] v = '0;
        for (int j = 0; j < 4; j++)
            if (t - j >= 0 && t - j < 4) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [127:0] m, input int t, input bit tr);
        logic [31:0] d = '0;
        for (int j = 0; j < 4; j++) begin
            int k = t - j;
            if (k >= 0 && k < 4)
                d[j*8 +: 8] = tr ? m[(k*4+j)*8 +: 8] : m[(j*4+k)*8 +: 8];
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] m);
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_row  = 2'(i);
            wr_data = m[i*32 +: 32];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_data, out_valid, busy, done, bank_ready, wr_full} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b busy=%b done=%b ready=%b full=%b, expected all 0",
                     out_data, out_valid, busy, done, bank_ready, wr_full);
        end
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || bank_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_empty: got busy=%b ready=%b, expected busy=0 ready=0", busy, bank_ready);
        end
    endtask

    task automatic test_stream(input bit tr);
        logic [127:0] m = mk_mat(0);
        logic [3:0] vt [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        load(m);
        commit();
        checks++;
        if (bank_ready !== 1'b1 || wr_full !== 1'b0) begin
            errors++;
            $display("FAIL commit_one: got ready=%b full=%b, expected ready=1 full=0", bank_ready, wr_full);
        end
        start = 1'b1;
        transpose = tr;
        tick();
        start = 1'b0;
        transpose = ~tr;
        checks++;
        if (busy !== 1'b0 || out_valid !== 4'b0) begin
            errors++;
            $display("FAIL accept_latency: got busy=%b valid=%b, expected busy=0 valid=0000", busy, out_valid);
        end
        for (int t = 0; t < 7; t++) begin
            tick();
            checks++;
            if (out_valid !== vt[t] || out_data !== exp_data(m, t, tr) || busy !== 1'b1 || done !== (t == 6)) begin
                errors++;
                $display("FAIL stream tr=%0d t=%0d: got valid=%b data=%h busy=%b done=%b, expected valid=%b data=%h busy=1 done=%b",
                         tr, t, out_valid, out_data, busy, done, vt[t], exp_data(m, t, tr), (t == 6));
            end
            if (!tr && t <= 3) begin
                checks++;
                if (out_data[7:0] !== 8'(t)) begin
                    errors++;
                    $display("FAIL lane0 t=%0d: got %0d, expected %0d", t, out_data[7:0], t);
                end
            end
            if (!tr && t >= 3) begin
                checks++;
                if (out_data[31:24] !== 8'(27 + t)) begin
                    errors++;
                    $display("FAIL lane3 t=%0d: got %0d, expected %0d", t, out_data[31:24], 27 + t);
                end
            end
            if (tr && t >= 1 && t <= 4) begin
                checks++;
                if (out_data[15:8] !== 8'(10*(t-1) + 1)) begin
                    errors++;
                    $display("FAIL lane1_transpose t=%0d: got %0d, expected %0d", t, out_data[15:8], 10*(t-1) + 1);
                end
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 4'b0 || out_data !== 32'b0 || bank_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream_end tr=%0d: got busy=%b done=%b valid=%b data=%h ready=%b, expected all 0",
                     tr, busy, done, out_valid, out_data, bank_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ma = mk_mat(0);
        logic [127:0] mb = mk_mat(1);
        int exp_cnt;
        load(ma);
        commit();
        start = 1'b1;
        transpose = 1'b0;
        tick();
        for (int c = 0; c < 14; c++) begin
            if (c < 4) begin
                wr_en = 1'b1;
                wr_row = 2'(c);
                wr_data = mb[c*32 +: 32];
            end else if (c == 4) begin
                wr_en = 1'b0;
                wr_commit = 1'b1;
            end else begin
                wr_commit = 1'b0;
            end
            if (c == 7) start = 1'b0;
            tick();
            exp_cnt = (c < 4) ? 1 : (c < 6) ? 2 : (c < 13) ? 1 : 0;
            checks++;
            if (out_valid !== exp_valid(c % 7) || out_data !== exp_data(c < 7 ? ma : mb, c % 7, 1'b0) ||
                busy !== 1'b1 || done !== (c == 6 || c == 13)) begin
                errors++;
                $display("FAIL b2b c=%0d: got valid=%b data=%h busy=%b done=%b, expected valid=%b data=%h busy=1 done=%b",
                         c, out_valid, out_data, busy, done, exp_valid(c % 7),
                         exp_data(c < 7 ? ma : mb, c % 7, 1'b0), (c == 6 || c == 13));
            end
            checks++;
            if (bank_ready !== (exp_cnt != 0) || wr_full !== (exp_cnt == 2)) begin
                errors++;
                $display("FAIL b2b_count c=%0d: got ready=%b full=%b, expected count %0d", c, bank_ready, wr_full, exp_cnt);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 4'b0 || out_data !== 32'b0) begin
            errors++;
            $display("FAIL b2b_end: got busy=%b valid=%b data=%h, expected 0", busy, out_valid, out_data);
        end
    endtask

    task automatic test_full();
        logic [127:0] mp = mk_mat(2);
        logic [127:0] mq = mk_mat(3);
        load(mp);
        commit();
        load(mq);
        commit();
        checks++;
        if (wr_full !== 1'b1 || bank_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_flag: got full=%b ready=%b, expected full=1 ready=1", wr_full, bank_ready);
        end
        wr_en = 1'b1;
        wr_row = 2'd0;
        wr_data = 32'hFFFF_FFFF;
        wr_commit = 1'b1;
        tick();
        wr_en = 1'b0;
        wr_commit = 1'b0;
        checks++;
        if (wr_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: got full=%b, expected 1", wr_full);
        end
        for (int b = 0; b < 2; b++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t < 7; t++) begin
                tick();
                checks++;
                if (out_data !== exp_data(b == 0 ? mp : mq, t, 1'b0) || out_valid !== exp_valid(t)) begin
                    errors++;
                    $display("FAIL full_stream b=%0d t=%0d: got data=%h valid=%b, expected data=%h valid=%b",
                             b, t, out_data, out_valid, exp_data(b == 0 ? mp : mq, t, 1'b0), exp_valid(t));
                end
            end
            tick();
            checks++;
            if (busy !== 1'b0 || bank_ready !== (b == 0) || wr_full !== 1'b0) begin
                errors++;
                $display("FAIL full_after b=%0d: got busy=%b ready=%b full=%b, expected busy=0 ready=%b full=0",
                         b, busy, bank_ready, wr_full, (b == 0));
            end
        end
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_start: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] m = mk_mat(0);
        logic [127:0] mn = mk_mat(3);
        load(m);
        commit();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        checks++;
        if (out_valid !== 4'b0111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got valid=%b busy=%b, expected valid=0111 busy=1", out_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 4'b0 || out_data !== 32'b0 || bank_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b valid=%b data=%h ready=%b, expected all 0",
                     busy, out_valid, out_data, bank_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || bank_ready !== 1'b0 || out_valid !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_start: got busy=%b ready=%b valid=%b, expected 0", busy, bank_ready, out_valid);
        end
        load(mn);
        commit();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            tick();
            checks++;
            if (out_data !== exp_data(mn, t, 1'b0) || out_valid !== exp_valid(t) || done !== (t == 6)) begin
                errors++;
                $display("FAIL post_reset_stream t=%0d: got data=%h valid=%b done=%b, expected data=%h valid=%b done=%b",
                         t, out_data, out_valid, done, exp_data(mn, t, 1'b0), exp_valid(t), (t == 6));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skew_mem.md
SKEW_MEM -- requirements
Module: skew_mem

Interface
REQ-001 Parameter BITS, default 8, element width in bits (signed two's complement, stored unaltered).
REQ-002 Parameter DIM, default 8, matrix dimension: rows, columns and output lanes; DIM >= 2.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  write wr_data into row wr_row of the current write bank.
REQ-006 wr_row  in  $clog2(DIM)  row index for a write.
REQ-007 wr_data  in  DIM*BITS  row data; column j at bits [j*BITS +: BITS].
REQ-008 wr_commit  in  1  single-cycle pulse marking the write bank complete and handing it to the read side.
REQ-009 start  in  1  request to stream the oldest committed bank.
REQ-010 transpose  in  1  stream mode, sampled only in the cycle start is accepted.
REQ-011 out_data  out  DIM*BITS  skewed lane data; lane j at bits [j*BITS +: BITS].
REQ-012 out_valid  out  DIM  per-lane valid.
REQ-013 busy  out  1  streaming in progress.
REQ-014 bank_ready  out  1  at least one committed bank is waiting (count >= 1).
REQ-015 wr_full  out  1  both banks committed (count == 2).
REQ-016 done  out  1  one-cycle pulse coincident with the last stream step.

Function
REQ-017 Storage: two banks (0, 1) of DIM x DIM elements; write-bank pointer wb, read-bank pointer rb, committed-bank count cnt in 0..2.
REQ-018 Write: wr_en with cnt < 2 stores wr_data to bank wb, row wr_row, at the clock edge; with cnt == 2 the write is ignored.
REQ-019 wr_commit with cnt < 2: cnt += 1, wb toggles; with cnt == 2 it is ignored. A write and a commit in the same cycle store first, then commit.
REQ-020 FSM states IDLE and STREAM; a step counter t runs 0 .. 2*DIM-2.
REQ-021 IDLE -> STREAM when start == 1 and cnt >= 1; t = 0 and the mode is latched from transpose. start in IDLE with cnt == 0 is ignored. start in STREAM is ignored.
REQ-022 Latency: start is accepted at edge N; step t = 0 is on the outputs after edge N+1 and stays for one cycle. Step t follows after edge N+1+t.
REQ-023 At step t, lane j has k = t - j. If 0 <= k < DIM: out_valid[j] = 1. With transpose = 0, lane j = M[j][k]; with transpose = 1, lane j = M[k][j]. Otherwise out_valid[j] = 0 and lane j = 0. M is bank rb, indexed [row][col].
REQ-024 busy = 1 for exactly the 2*DIM-1 step cycles, 0 otherwise.
REQ-025 done = 1 only in the t = 2*DIM-2 step cycle.
REQ-026 At the edge ending the last step, the block returns to IDLE, rb toggles and cnt -= 1. All outputs return to 0 in the following cycle.
REQ-027 If start is high with cnt >= 1 at that same edge, the FSM re-enters STREAM directly on the new rb with no idle cycle (back-to-back streaming).
REQ-028 Commit and stream end at the same edge: cnt is unchanged, wb and rb both toggle.
REQ-029 Writes during STREAM always target bank wb, which never equals rb while streaming. Streamed data is never corrupted by concurrent writes.
REQ-030 All outputs are registered; bank_ready and wr_full reflect cnt after the edge.

Reset
REQ-031 While rst is asserted (asynchronously, any cycle including mid-stream), the following hold: FSM = IDLE, t = 0, cnt = 0, wb = rb = 0, out_data = 0, out_valid = 0, busy = done = bank_ready = wr_full = 0.
REQ-032 Bank contents are not reset. Data committed before reset is discarded logically, and reads of unwritten rows are unspecified.

Verification (DIM=4, BITS=8)
REQ-033 Write rows M[i][j] = 10*i + j, commit, start with transpose = 0. Expected over the 7 step cycles: lane 0 gives 0, 1, 2, 3 at t = 0..3. Lane 3 gives 30, 31, 32, 33 at t = 3..6. out_valid = 0001, 0011, 0111, 1111, 1110, 1100, 1000. done only at t = 6.
REQ-034 Same data with transpose = 1. Lane 1 gives 1, 11, 21, 31 at t = 1..4.
REQ-035 Commit bank 0, start, then write and commit bank 1 during streaming (values -1..-16) with start held high. Expected: bank 0 streams unaltered, then bank 1 streams immediately after t = 6 with no gap; cnt goes 1 -> 2 -> 1 -> 0.
REQ-036 Commit twice, then write with wr_en and a third commit. Expected: wr_full = 1, write and commit are ignored, and the streamed banks hold the original data. start with cnt == 0 leaves busy = 0.
REQ-037 Assert rst at t = 2. Expected: busy, out_valid and out_data are 0 without waiting for a clock edge; afterwards bank_ready = 0 and start does nothing until a new commit.
